// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and op-decode helpers for the multiply/divide unit.
package muldiv_pkg;

    // ALUControl codes as produced by the main decoder
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_UMULL = 4'b0110;
    localparam logic [3:0] OP_SMULL = 4'b1000;
    localparam logic [3:0] OP_UDIV  = 4'b0111;
    localparam logic [3:0] OP_SDIV  = 4'b1001;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_UDIV) || (op == OP_SDIV);
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_SMULL) || (op == OP_SDIV);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_UMULL) || (op == OP_SMULL) ||
               (op == OP_UDIV) || (op == OP_SDIV);
    endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation; used both to take magnitudes and to restore signs.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] in_val,
    output logic [W-1:0] out_val
);

    // Pass through, or negate when enabled (most-negative value maps onto itself as an unsigned magnitude)
    always_comb begin
        out_val = en ? (~in_val + W'(1)) : in_val;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit: WIDTH iterations plus a sign-fix cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             div0,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic               div0_q, div0_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH-1:0]   a_abs, b_abs, quo_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     add_sum, rem_shift, rem_diff;

    // Operand magnitudes for signed ops, taken straight from the request inputs
    muldiv_negate #(.W(WIDTH)) u_abs_a (
        .en(is_signed(op) & a[WIDTH-1]), .in_val(a), .out_val(a_abs)
    );
    muldiv_negate #(.W(WIDTH)) u_abs_b (
        .en(is_signed(op) & b[WIDTH-1]), .in_val(b), .out_val(b_abs)
    );

    // Sign restoration applied in the fix cycle
    muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
        .en((op_q == OP_SMULL) & (sign_a_q ^ sign_b_q)), .in_val(acc_q), .out_val(prod_fix)
    );
    muldiv_negate #(.W(WIDTH)) u_fix_quo (
        .en((op_q == OP_SDIV) & (sign_a_q ^ sign_b_q)), .in_val(acc_q[WIDTH-1:0]), .out_val(quo_fix)
    );
    muldiv_negate #(.W(WIDTH)) u_fix_rem (
        .en((op_q == OP_SDIV) & sign_a_q), .in_val(acc_q[2*WIDTH-1:WIDTH]), .out_val(rem_fix)
    );

    // Per-iteration arithmetic: shift-add partial sum and restoring-division trial subtract
    always_comb begin
        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, bmag_q};
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, bmag_q};
    end

    // Control FSM and next-state datapath; acc holds {upper, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        bmag_d    = bmag_q;
        acc_d     = acc_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        div0_d    = div0_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d      = op;
                    div0_d    = 1'b0;
                    illegal_d = 1'b0;
                    if (!is_legal(op)) begin
                        res_lo_d  = '0;
                        res_hi_d  = '0;
                        illegal_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (is_div(op) && (b == '0)) begin
                        res_lo_d = '0;
                        res_hi_d = a;
                        div0_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        sign_a_d = is_signed(op) & a[WIDTH-1];
                        sign_b_d = is_signed(op) & b[WIDTH-1];
                        bmag_d   = b_abs;
                        acc_d    = {{WIDTH{1'b0}}, a_abs};
                        cnt_d    = '0;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (is_div(op_q)) begin
                    if (!rem_diff[WIDTH]) begin
                        acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (acc_q[0]) begin
                        acc_d = {add_sum, acc_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                    end
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                if (is_div(op_q)) begin
                    res_lo_d = quo_fix;
                    res_hi_d = rem_fix;
                end else begin
                    res_lo_d = prod_fix[WIDTH-1:0];
                    res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                end
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            bmag_q    <= '0;
            acc_q     <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            div0_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            bmag_q    <= bmag_d;
            acc_q     <= acc_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            div0_q    <= div0_d;
            illegal_q <= illegal_d;
        end
    end

    assign busy    = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done    = (state_q == ST_DONE);
    assign res_lo  = res_lo_q;
    assign res_hi  = res_hi_q;
    assign div0    = div0_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes reference results, a monitor checks each done pulse.
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        div0;
        logic        ill;
        int          lat;
        int          accept;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        div0;
    logic        illegal;

    exp_t sb[$];
    int   cycle_cnt = 0;
    int   n_checks  = 0;
    int   n_fails   = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .res_lo(res_lo), .res_hi(res_hi),
        .div0(div0), .illegal(illegal)
    );

    // Free-running clock and an edge counter used to measure latency
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Single comparison point: every check is counted here and failures are reported here
    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model from the arithmetic definition of each op, using 64-bit integer math
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy;
        logic [63:0] p;
        sx = $signed(x);
        sy = $signed(y);
        e.lo = '0; e.hi = '0; e.div0 = 1'b0; e.ill = 1'b0; e.lat = WIDTH + 2; e.accept = 0;
        case (o)
            4'b0100, 4'b0110: begin
                p = {32'd0, x} * {32'd0, y};
                e.lo = p[31:0]; e.hi = p[63:32];
            end
            4'b1000: begin
                p = sx * sy;
                e.lo = p[31:0]; e.hi = p[63:32];
            end
            4'b0111, 4'b1001: begin
                if (y == 0) begin
                    e.hi = x; e.div0 = 1'b1; e.lat = 1;
                end else if (o == 4'b0111) begin
                    e.lo = x / y; e.hi = x % y;
                end else begin
                    e.lo = 32'(sx / sy); e.hi = 32'(sx % sy);
                end
            end
            default: begin
                e.ill = 1'b1; e.lat = 1;
            end
        endcase
        return e;
    endfunction

    // Monitor: checks busy against the expected timeline and compares every done pulse with the queue head
    always @(negedge clk) begin
        if (reset) begin
            if (sb.size() > 0) begin
                int since;
                since = cycle_cnt - sb[0].accept;
                if (done) begin
                    check_output("latency", 64'(since), 64'(sb[0].lat));
                    check_output("res_lo", 64'(res_lo), 64'(sb[0].lo));
                    check_output("res_hi", 64'(res_hi), 64'(sb[0].hi));
                    check_output("div0", 64'(div0), 64'(sb[0].div0));
                    check_output("illegal", 64'(illegal), 64'(sb[0].ill));
                    check_output("busy_at_done", 64'(busy), 64'd0);
                    void'(sb.pop_front());
                end else if (since > sb[0].lat + 4) begin
                    check_output("timeout_done", 64'd0, 64'd1);
                    void'(sb.pop_front());
                end else begin
                    check_output("busy", 64'(busy), 64'((since >= 1) && (since < sb[0].lat)));
                end
            end else if (done) begin
                check_output("unexpected_done", 64'(done), 64'd0);
            end
        end
    end

    // Issue one request, scramble inputs while it runs, optionally poke start or pulse reset mid-operation
    task automatic apply_stimulus(input logic [3:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                                  input int poke_at = -1, input int reset_at = -1);
        exp_t e;
        @(negedge clk);
        e = model(op_i, a_i, b_i);
        e.accept = cycle_cnt;
        sb.push_back(e);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 60 && sb.size() > 0; k++) begin
            op = 4'($urandom); a = $urandom; b = $urandom;
            if (k == poke_at) begin
                start = 1'b1; op = 4'b0111; b = 32'd1;
            end
            if (k == reset_at) begin
                reset = 1'b0;
                sb.delete();
                #1;
                check_output("rst_res_lo", 64'(res_lo), 64'd0);
                check_output("rst_res_hi", 64'(res_hi), 64'd0);
                check_output("rst_busy", 64'(busy), 64'd0);
                check_output("rst_done", 64'(done), 64'd0);
                check_output("rst_div0", 64'(div0), 64'd0);
                check_output("rst_illegal", 64'(illegal), 64'd0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    // Directed cases first, then randomized requests including corner operands
    initial begin
        logic [3:0]  ops [7];
        logic [31:0] ra, rb;
        ops = '{4'b0100, 4'b0110, 4'b1000, 4'b0111, 4'b1001, 4'b0000, 4'b1111};
        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        #2;
        check_output("init_res_lo", 64'(res_lo), 64'd0);
        check_output("init_res_hi", 64'(res_hi), 64'd0);
        check_output("init_busy", 64'(busy), 64'd0);
        check_output("init_done", 64'(done), 64'd0);
        check_output("init_div0", 64'(div0), 64'd0);
        check_output("init_illegal", 64'(illegal), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        apply_stimulus(4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        apply_stimulus(4'b1000, 32'hFFFF_FFFE, 32'd3);
        apply_stimulus(4'b0100, 32'hFFFF_FFFE, 32'd3);
        apply_stimulus(4'b1001, 32'hFFFF_FFF9, 32'd2);
        apply_stimulus(4'b1001, 32'h8000_0000, 32'hFFFF_FFFF);
        apply_stimulus(4'b0111, 32'd100, 32'd0);
        apply_stimulus(4'b0111, 32'd100, 32'd7);
        apply_stimulus(4'b0110, 32'h1234_5678, 32'h9ABC_DEF0, 10);
        apply_stimulus(4'b0000, 32'h1111_1111, 32'h2222_2222);
        apply_stimulus(4'b1000, 32'h8765_4321, 32'h0FED_CBA9, -1, 15);
        apply_stimulus(4'b1000, 32'h8765_4321, 32'h0FED_CBA9);
        apply_stimulus(4'b1001, 32'd7, 32'hFFFF_FFFE);
        apply_stimulus(4'b1000, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            apply_stimulus(ops[$urandom_range(0, 6)], ra, rb);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
